// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
// AHB-Lite responder in front of an on-chip word-organised SRAM.
// Each OKAY data phase lasts WAIT_STATES+1 cycles. Misaligned or oversized
// transfers get a two-cycle ERROR response and never touch the memory.
//
// Ports:
//   HCLK, HRESETn       bus clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE       address-phase controls from the master/decoder
//   HWDATA              write data (data phase)
//   HREADY              muxed bus ready
//   HRDATA              read data (valid in the completing cycle)
//   HREADYOUT, HRESP    this slave's ready and response

`ifndef AHB_ADDR_BITS
`define AHB_ADDR_BITS 32
`endif
`ifndef AHB_DATA_BITS
`define AHB_DATA_BITS 32
`endif
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif
`ifndef AHB_RESP_BITS
`define AHB_RESP_BITS 2
`endif

module ahb_sram_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        HSEL,
  input  logic [`AHB_ADDR_BITS-1:0]   HADDR,
  input  logic [`AHB_TRANS_BITS-1:0]  HTRANS,
  input  logic                        HWRITE,
  input  logic [`AHB_SIZE_BITS-1:0]   HSIZE,
  input  logic [`AHB_DATA_BITS-1:0]   HWDATA,
  input  logic                        HREADY,
  output logic [`AHB_DATA_BITS-1:0]   HRDATA,
  output logic                        HREADYOUT,
  output logic [`AHB_RESP_BITS-1:0]   HRESP
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int SZ_W   = `AHB_SIZE_BITS;
  localparam int RESP_W = `AHB_RESP_BITS;
  localparam int LANES  = `AHB_DATA_BITS / 8;

  localparam logic [SZ_W-1:0]   SIZE_HALF = SZ_W'(1);
  localparam logic [SZ_W-1:0]   SIZE_WORD = SZ_W'(2);
  localparam logic [RESP_W-1:0] RESP_OKAY = RESP_W'(0);
  localparam logic [RESP_W-1:0] RESP_ERR  = RESP_W'(1);
  localparam logic [2:0]        CNT_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                     state_reg, state_next;
  logic [2:0]                 cnt_reg, cnt_next;
  logic                       done_reg, done_next;   // next cycle completes an OKAY data phase
  logic [IDX_W+1:0]           addr_reg;
  logic                       write_reg;
  logic [1:0]                 size_reg;
  logic [`AHB_DATA_BITS-1:0]  hrdata_reg;

  logic [`AHB_DATA_BITS-1:0]  mem [DEPTH];

  logic                       accept, req_err, take_new;
  logic                       wr_en, fetch_write, bypass;
  logic [IDX_W-1:0]           wr_idx, fetch_idx;
  logic [LANES-1:0]           wr_mask;

  logic unused_bits;
  assign unused_bits = ^{HADDR[`AHB_ADDR_BITS-1:IDX_W+2], HTRANS[0]};

  assign accept  = HSEL & HTRANS[1] & HREADY;
  assign req_err = (HSIZE > SIZE_WORD)
                 | ((HSIZE == SIZE_HALF) & HADDR[0])
                 | ((HSIZE == SIZE_WORD) & (HADDR[1:0] != 2'b00));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    take_new   = 1'b0;
    case (state_reg)
      S_IDLE: take_new = accept;
      S_WAIT: begin
        if (cnt_reg == 3'd0) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      S_ERR1: state_next = S_ERR2;
      S_ERR2: begin
        state_next = S_IDLE;
        take_new   = accept;
      end
      default: state_next = S_IDLE;
    endcase
    if (take_new) begin
      if (req_err) begin
        state_next = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_next = S_WAIT;
        cnt_next   = CNT_LOAD;
      end else begin
        state_next = S_IDLE;
        done_next  = 1'b1;
      end
    end
  end

  // Lane enables of the transfer completing in this cycle (only legal
  // size/offset combinations ever get here).
  always_comb begin
    wr_mask = '1;
    case (size_reg)
      2'd0:    wr_mask = LANES'(1) << addr_reg[1:0];
      2'd1:    wr_mask = addr_reg[1] ? 4'b1100 : 4'b0011;
      default: wr_mask = '1;
    endcase
  end

  assign wr_en  = done_reg & write_reg;
  assign wr_idx = addr_reg[IDX_W+1:2];

  // The RAM read is issued on the edge entering the completing cycle. With
  // no wait states that is the acceptance edge, so the address comes
  // straight from the bus; otherwise from the captured address.
  assign fetch_write = (WAIT_STATES == 0) ? HWRITE : write_reg;
  assign fetch_idx   = (WAIT_STATES == 0) ? HADDR[IDX_W+1:2] : addr_reg[IDX_W+1:2];

  // A write completing on the same edge the read is fetched must be
  // forwarded, otherwise a read straight after a write sees stale data.
  assign bypass = wr_en & (wr_idx == fetch_idx);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 3'd0;
      done_reg   <= 1'b0;
      addr_reg   <= '0;
      write_reg  <= 1'b0;
      size_reg   <= 2'd0;
      hrdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      if (take_new) begin
        addr_reg  <= HADDR[IDX_W+1:0];
        write_reg <= HWRITE;
        size_reg  <= HSIZE[1:0];
      end
      if (done_next && !fetch_write) begin
        for (int i = 0; i < LANES; i++) begin
          hrdata_reg[8*i +: 8] <= (bypass && wr_mask[i]) ? HWDATA[8*i +: 8]
                                                         : mem[fetch_idx][8*i +: 8];
        end
      end else if (take_new && req_err) begin
        hrdata_reg <= '0;
      end
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_mask[i]) begin
          mem[wr_idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign HREADYOUT = !((state_reg == S_WAIT) || (state_reg == S_ERR1));
  assign HRESP     = ((state_reg == S_ERR1) || (state_reg == S_ERR2)) ? RESP_ERR : RESP_OKAY;
  assign HRDATA    = hrdata_reg;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Two slaves on one bus: slave 1 (WAIT_STATES=1) at 0x0000, slave 0
// (WAIT_STATES=0) at 0x1000. The bench plays master and interconnect,
// pushes the expected response of every transfer into a queue, and an
// independent monitor pops and compares at each completing data phase.

`ifndef AHB_ADDR_BITS
`define AHB_ADDR_BITS 32
`endif
`ifndef AHB_DATA_BITS
`define AHB_DATA_BITS 32
`endif
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif
`ifndef AHB_RESP_BITS
`define AHB_RESP_BITS 2
`endif

module tb_ahb_sram_slave;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic                       HRESETn;
  logic [`AHB_ADDR_BITS-1:0]  haddr;
  logic [`AHB_TRANS_BITS-1:0] htrans;
  logic                       hwrite;
  logic [`AHB_SIZE_BITS-1:0]  hsize;
  logic [`AHB_DATA_BITS-1:0]  hwdata;
  logic                       hsel1, hsel0, hready, dp_sel;
  logic [`AHB_DATA_BITS-1:0]  hrdata1, hrdata0, hrdata;
  logic                       hreadyout1, hreadyout0;
  logic [`AHB_RESP_BITS-1:0]  hresp1, hresp0, hresp;

  // Address decoder and slave-to-master mux.
  assign hsel1  = ~haddr[12];
  assign hsel0  = haddr[12];
  assign hready = dp_sel ? hreadyout0 : hreadyout1;
  assign hrdata = dp_sel ? hrdata0 : hrdata1;
  assign hresp  = dp_sel ? hresp0 : hresp1;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dp_sel <= 1'b0;
    else if (hready) dp_sel <= haddr[12];
  end

  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(1)) dut_ws1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(hrdata1), .HREADYOUT(hreadyout1), .HRESP(hresp1));

  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(0)) dut_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0));

  typedef struct {
    int          tag;
    int          waits;
    logic [1:0]  resp;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_cnt = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int req);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  // Monitor: at every falling edge look at the active data phase; on a
  // ready cycle pop the oldest expectation and compare.
  initial begin : monitor
    bit   mon_active = 1'b0;
    int   waits_seen = 0;
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        mon_active = 1'b0;
        waits_seen = 0;
        exp_q.delete();
      end else begin
        if (mon_active) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_data_phase", 1, 0);
            waits_seen = 0;
          end else if (!hready) begin
            waits_seen++;
            check32($sformatf("t%0d_wait_resp", exp_q[0].tag), 32'(hresp), 32'(exp_q[0].resp));
          end else begin
            e = exp_q.pop_front();
            $display("txn %0d complete waits=%0d resp=%0d rdata=%h", e.tag, waits_seen, hresp, hrdata);
            check32($sformatf("t%0d_waits", e.tag), 32'(waits_seen), 32'(e.waits));
            check32($sformatf("t%0d_resp", e.tag), 32'(hresp), 32'(e.resp));
            if (e.chk_data) check32($sformatf("t%0d_rdata", e.tag), hrdata, e.data);
            waits_seen = 0;
          end
        end
        if (hready) mon_active = htrans[1];
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge HCLK);
    while (!hready && n < 20) begin
      @(negedge HCLK);
      n++;
    end
    if (!hready) fail_now("ready_timeout", n, 20);
  endtask

  // Drive one address phase; returns 1 ns after it is accepted, with the
  // write data placed on the bus for the data phase that just started.
  task automatic issue(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                       input logic [31:0] wd, input int w, input logic [1:0] r,
                       input bit cd, input logic [31:0] d);
    exp_t e;
    e.tag = tag_cnt; e.waits = w; e.resp = r; e.chk_data = cd; e.data = d;
    tag_cnt++;
    exp_q.push_back(e);
    haddr = a; hwrite = wr; hsize = sz; htrans = 2'b10;
    wait_ready();
    @(posedge HCLK); #1;
    htrans = 2'b00;
    if (wr) hwdata = wd;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge HCLK); #1;
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout", exp_q.size(), 0);
    @(posedge HCLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0;
    haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; hwdata = '0;
    #3;
    check32("rst_ws1_hreadyout", 32'(hreadyout1), 32'd1);
    check32("rst_ws1_hresp", 32'(hresp1), 32'd0);
    check32("rst_ws1_hrdata", hrdata1, 32'h0);
    check32("rst_ws0_hreadyout", 32'(hreadyout0), 32'd1);
    check32("rst_ws0_hresp", 32'(hresp0), 32'd0);
    check32("rst_ws0_hrdata", hrdata0, 32'h0);
    @(negedge HCLK); @(negedge HCLK); #2;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Word write/read with one wait state.
    issue(32'h10, 1, 3'd2, 32'hDEADBEEF, 1, 2'b00, 0, 32'h0);
    issue(32'h10, 0, 3'd2, 32'h0,        1, 2'b00, 1, 32'hDEADBEEF);
    drain();

    // Byte and halfword lanes.
    issue(32'h11, 1, 3'd0, 32'h00005500, 1, 2'b00, 0, 32'h0);
    issue(32'h12, 1, 3'd1, 32'hA5A50000, 1, 2'b00, 0, 32'h0);
    issue(32'h10, 0, 3'd2, 32'h0,        1, 2'b00, 1, 32'hA5A555EF);
    drain();

    // Zero-wait back-to-back on slave 0, read right after write of same word.
    issue(32'h1020, 1, 3'd2, 32'h11112222, 0, 2'b00, 0, 32'h0);
    issue(32'h1024, 1, 3'd2, 32'h33334444, 0, 2'b00, 0, 32'h0);
    issue(32'h1024, 0, 3'd2, 32'h0,        0, 2'b00, 1, 32'h33334444);
    issue(32'h1020, 0, 3'd2, 32'h0,        0, 2'b00, 1, 32'h11112222);
    drain();

    // Error responses: misaligned halfword, misaligned word, oversize, and
    // an error on the zero-wait slave; the targeted words stay unchanged.
    issue(32'h20,   1, 3'd2, 32'hCAFEF00D, 1, 2'b00, 0, 32'h0);
    issue(32'h01,   0, 3'd1, 32'h0,        1, 2'b01, 1, 32'h0);
    issue(32'h22,   1, 3'd2, 32'hFFFFFFFF, 1, 2'b01, 1, 32'h0);
    issue(32'h20,   0, 3'd3, 32'h0,        1, 2'b01, 1, 32'h0);
    issue(32'h1021, 1, 3'd1, 32'hFFFFFFFF, 1, 2'b01, 1, 32'h0);
    issue(32'h20,   0, 3'd2, 32'h0,        1, 2'b00, 1, 32'hCAFEF00D);
    issue(32'h1020, 0, 3'd2, 32'h0,        0, 2'b00, 1, 32'h11112222);
    drain();

    // Reset during the wait cycle of a write aborts it.
    issue(32'h30, 1, 3'd2, 32'h12345678, 1, 2'b00, 0, 32'h0);
    drain();
    issue(32'h30, 1, 3'd2, 32'hBADBAD00, 1, 2'b00, 0, 32'h0);
    @(negedge HCLK); #2;
    HRESETn = 1'b0;
    #1;
    check32("midrst_hreadyout", 32'(hreadyout1), 32'd1);
    check32("midrst_hresp", 32'(hresp1), 32'd0);
    check32("midrst_hrdata", hrdata1, 32'h0);
    @(negedge HCLK); #2;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    issue(32'h30, 0, 3'd2, 32'h0, 1, 2'b00, 1, 32'h12345678);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
